// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, colour type, clear FSM states and the
// linear address helper used by the frame fetch stage.
package vga_pkg;

    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned FB_W        = 160;
    localparam int unsigned FB_H        = 120;
    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned FB_SIZE     = FB_W * FB_H;
    localparam int unsigned FX_W        = 8;
    localparam int unsigned FY_W        = 7;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fetch_state_e;

    // fy*160 + fx built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [FX_W-1:0] fx,
                                                  input logic [FY_W-1:0] fy);
        return (ADDR_W'(fy) << 7) + (ADDR_W'(fy) << 5) + ADDR_W'(fx);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port frame-buffer RAM, synchronous read with one cycle of latency.
module fb_ram
    import vga_pkg::*;
#(
    parameter int unsigned AW = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  rgb_t          din,
    output rgb_t          dout
);

    rgb_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/frame_fetch.sv
// Scales active VGA pixels 4:1 onto a 160x120 RGB frame buffer, arbitrates
// host writes and a hardware clear into the free RAM slots.
module frame_fetch
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic       in_active,
    output logic       r_out,
    output logic       g_out,
    output logic       b_out,
    output logic       h_sync,
    output logic       v_sync,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic [2:0] wr_rgb,
    input  logic       clr_start,
    input  logic [2:0] clr_rgb,
    output logic       clr_busy,
    output logic       wr_oob
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    rgb_t              clr_col_q, clr_col_d;
    logic              oob_d;

    logic              fetch_c;
    logic              wr_in_range_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [ADDR_W-1:0] wr_addr_c;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    rgb_t              ram_din;
    rgb_t              ram_dout;

    logic              fetch_q;
    logic              act_q;
    logic              hs_q;
    logic              vs_q;
    rgb_t              pix_q;
    rgb_t              pix_sel_c;

    assign fetch_c       = pix_en & in_active;
    assign rd_addr_c     = fb_addr(FX_W'(pix_x >> SCALE_SHIFT), FY_W'(pix_y >> SCALE_SHIFT));
    assign wr_addr_c     = fb_addr(wr_x, wr_y);
    assign wr_in_range_c = (wr_x < FX_W'(FB_W)) && (wr_y < FY_W'(FB_H));
    assign clr_busy      = (state_q == CLEAR);

    fb_ram #(.AW(ADDR_W)) u_fb_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    // Clear FSM state, counter, latched colour and sticky out-of-range flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            clr_col_q <= '0;
            wr_oob    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_col_q <= clr_col_d;
            wr_oob    <= oob_d;
        end
    end

    // Fetch owns the port whenever it wants it; host/clear use the rest
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_col_d = clr_col_q;
        oob_d     = wr_oob;
        wr_ready  = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = rd_addr_c;
        ram_din   = rgb_t'(wr_rgb);

        case (state_q)
            IDLE: begin
                wr_ready = !fetch_c;
                if (wr_valid && !fetch_c) begin
                    if (wr_in_range_c) begin
                        ram_we   = 1'b1;
                        ram_addr = wr_addr_c;
                    end else begin
                        oob_d = 1'b1;
                    end
                end
                if (clr_start) begin
                    clr_col_d = rgb_t'(clr_rgb);
                    cnt_d     = '0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                if (!fetch_c) begin
                    ram_we   = 1'b1;
                    ram_addr = cnt_q;
                    ram_din  = clr_col_q;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM data is only valid the cycle after a fetch, so keep a copy for later ticks
    assign pix_sel_c = fetch_q ? ram_dout : pix_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_q <= 1'b0;
            pix_q   <= '0;
            act_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            r_out   <= 1'b0;
            g_out   <= 1'b0;
            b_out   <= 1'b0;
            h_sync  <= 1'b1;
            v_sync  <= 1'b1;
        end else begin
            fetch_q <= fetch_c;
            if (fetch_q) begin
                pix_q <= ram_dout;
            end
            if (pix_en) begin
                act_q  <= in_active;
                hs_q   <= in_hsync;
                vs_q   <= in_vsync;
                r_out  <= act_q & pix_sel_c.r;
                g_out  <= act_q & pix_sel_c.g;
                b_out  <= act_q & pix_sel_c.b;
                h_sync <= hs_q;
                v_sync <= vs_q;
            end
        end
    end

endmodule

// File: tb/tb_frame_fetch.sv
// Randomized bench for frame_fetch against a 2-D frame-buffer reference model.
module tb_frame_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       in_hsync;
    logic       in_vsync;
    logic       in_active;
    logic       r_out;
    logic       g_out;
    logic       b_out;
    logic       h_sync;
    logic       v_sync;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic [2:0] wr_rgb;
    logic       clr_start;
    logic [2:0] clr_rgb;
    logic       clr_busy;
    logic       wr_oob;

    frame_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .in_active (in_active),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_rgb    (wr_rgb),
        .clr_start (clr_start),
        .clr_rgb   (clr_rgb),
        .clr_busy  (clr_busy),
        .wr_oob    (wr_oob)
    );

    always #5 clk = ~clk;

    // Reference model: frame buffer as a 2-D picture plus a one-tick delay line
    logic [2:0] fb [0:159][0:119];
    logic [2:0] o_exp   = 3'b000;
    logic [2:0] pend    = 3'b000;
    logic       hs_exp  = 1'b1;
    logic       vs_exp  = 1'b1;
    logic       pend_hs = 1'b1;
    logic       pend_vs = 1'b1;
    bit         m_busy  = 1'b0;
    bit         m_oob   = 1'b0;
    int         m_left  = 0;
    logic [2:0] m_col   = 3'b000;

    bit chk_out   = 1'b1;
    bit chk_ready = 1'b0;
    bit auto_wr   = 1'b0;
    int checks    = 0;
    int errors    = 0;

    task automatic new_random_write();
        wr_x   = 8'($urandom_range(7));
        wr_y   = 7'($urandom_range(7));
        wr_rgb = 3'($urandom_range(7));
    endtask

    // One clk cycle: inputs already driven at the negedge; checks at the next negedge
    task automatic advance(output bit acc);
        bit         free;
        bit         exp_ready;
        logic [7:0] fx;
        logic [6:0] fy;
        free      = !(pix_en && in_active);
        exp_ready = free && !m_busy;
        #1;
        if (chk_ready) begin
            checks++;
            if (wr_ready !== exp_ready) begin
                errors++;
                $display("FAIL wr_ready: got %b expected %b at %0t", wr_ready, exp_ready, $time);
            end
        end
        acc = wr_valid && exp_ready;
        @(posedge clk);
        if (!rst) begin
            o_exp = 3'b000; pend = 3'b000;
            hs_exp = 1'b1; vs_exp = 1'b1; pend_hs = 1'b1; pend_vs = 1'b1;
            m_busy = 1'b0; m_oob = 1'b0; m_left = 0;
            acc = 1'b0;
        end else begin
            if (pix_en) begin
                o_exp  = pend;
                hs_exp = pend_hs;
                vs_exp = pend_vs;
                fx     = 8'(pix_x >> 2);
                fy     = 7'(pix_y >> 2);
                pend    = in_active ? fb[fx][fy] : 3'b000;
                pend_hs = in_hsync;
                pend_vs = in_vsync;
            end
            if (acc) begin
                if (wr_x < 8'd160 && wr_y < 7'd120) fb[wr_x][wr_y] = wr_rgb;
                else m_oob = 1'b1;
            end
            if (m_busy) begin
                if (free) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        for (int i = 0; i < 160; i++)
                            for (int j = 0; j < 120; j++)
                                fb[8'(i)][7'(j)] = m_col;
                    end
                end
            end else if (clr_start) begin
                m_busy = 1'b1;
                m_left = 160 * 120;
                m_col  = clr_rgb;
            end
        end
        @(negedge clk);
        if (chk_out) begin
            checks++;
            if ({r_out, g_out, b_out} !== o_exp) begin
                errors++;
                $display("FAIL rgb_out: got %b expected %b at %0t", {r_out, g_out, b_out}, o_exp, $time);
            end
            checks++;
            if ({h_sync, v_sync} !== {hs_exp, vs_exp}) begin
                errors++;
                $display("FAIL syncs: got %b expected %b at %0t", {h_sync, v_sync}, {hs_exp, vs_exp}, $time);
            end
        end
        checks++;
        if (clr_busy !== m_busy) begin
            errors++;
            $display("FAIL clr_busy: got %b expected %b at %0t", clr_busy, m_busy, $time);
        end
        checks++;
        if (wr_oob !== m_oob) begin
            errors++;
            $display("FAIL wr_oob: got %b expected %b at %0t", wr_oob, m_oob, $time);
        end
        if (acc && auto_wr) new_random_write();
    endtask

    task automatic tick(input int x, input int y, input bit act, input bit hs, input bit vs);
        bit a;
        pix_en = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        in_active = act; in_hsync = hs; in_vsync = vs;
        advance(a);
        pix_en = 1'b0;
        advance(a);
    endtask

    task automatic host_write(input int x, input int y, input logic [2:0] rgb);
        bit a;
        int n;
        wr_valid = 1'b1; wr_x = 8'(x); wr_y = 7'(y); wr_rgb = rgb;
        a = 1'b0;
        n = 0;
        while (!a && n < 8) begin
            advance(a);
            n++;
        end
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL host_write_accept: got none expected accept within 8 cycles");
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit a;
        rst = 1'b0; pix_en = 1'b0; pix_x = '0; pix_y = '0;
        in_active = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
        clr_start = 1'b0; clr_rgb = '0;
        for (int i = 0; i < 4; i++) advance(a);
        rst = 1'b1;
        chk_ready = 1'b1;
        for (int i = 0; i < 3; i++) advance(a);
    endtask

    task automatic test_clear();
        bit a;
        int n;
        clr_rgb = 3'b010; clr_start = 1'b1;
        wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd3; wr_rgb = 3'b111;
        auto_wr = 1'b1;
        advance(a);
        clr_start = 1'b0;
        chk_out = 1'b0;
        n = 0;
        while ((m_busy || clr_busy) && n < 30000) begin
            pix_en    = n[0];
            in_active = 1'($urandom_range(1));
            pix_x     = 10'($urandom_range(639));
            pix_y     = 10'($urandom_range(479));
            in_hsync  = 1'($urandom_range(1));
            in_vsync  = 1'($urandom_range(1));
            clr_start = (n == 100);
            clr_rgb   = (n == 100) ? 3'b111 : 3'b010;
            advance(a);
            n++;
        end
        checks++;
        if (n >= 30000) begin
            errors++;
            $display("FAIL clear_done: got busy after %0d cycles expected done", n);
        end
        clr_start = 1'b0; wr_valid = 1'b0; auto_wr = 1'b0;
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        chk_out = 1'b1;
        for (int i = 0; i < 600; i++)
            tick(int'($urandom_range(639)), int'($urandom_range(479)), 1'b1,
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_host_write();
        host_write(10, 5, 3'b101);
        for (int y = 19; y <= 24; y++)
            for (int x = 39; x <= 44; x++)
                tick(x, y, 1'b1, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_latency();
        tick(41, 21, 1'b1, 1'b1, 1'b1);
        tick(100, 50, 1'b1, 1'b0, 1'b1);
        tick(41, 22, 1'b1, 1'b1, 1'b0);
        tick(42, 20, 1'b0, 1'b0, 1'b0);
        tick(43, 23, 1'b1, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_arbitration();
        new_random_write();
        wr_valid = 1'b1;
        auto_wr  = 1'b1;
        for (int i = 0; i < 1500; i++)
            tick(int'($urandom_range(31)), int'($urandom_range(31)), ($urandom_range(9) < 8),
                 1'($urandom_range(1)), 1'($urandom_range(1)));
        wr_valid = 1'b0;
        auto_wr  = 1'b0;
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++)
                tick(x, y, 1'b1, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_oob();
        host_write(160, 0, 3'b111);
        tick(0, 4, 1'b1, 1'b1, 1'b1);
        tick(2, 5, 1'b1, 1'b1, 1'b1);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
        host_write(5, 120, 3'b111);
        tick(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_clear();
        bit a;
        clr_rgb = 3'b001; clr_start = 1'b1;
        advance(a);
        clr_start = 1'b0;
        chk_out = 1'b0;
        for (int i = 0; i < 20; i++) advance(a);
        rst = 1'b0;
        advance(a);
        rst = 1'b1;
        chk_out = 1'b1;
        for (int i = 0; i < 3; i++) advance(a);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_host_write();
        test_latency();
        test_arbitration();
        test_oob();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
